// File: rtl/z_move_sequencer_if.sv
// Command channel and Z stepper handshake bundle for z_move_sequencer.
// The slave modport is the sequencer side; the master modport is the host/stepper side.
interface z_move_sequencer_if;
    logic               cmd_valid;
    logic               cmd_ready;
    logic signed [31:0] cmd_step;
    logic        [31:0] cmd_speed;
    logic               flush;
    logic signed [31:0] stepper_step_in;
    logic        [31:0] stepper_speed;
    logic               start_driving;
    logic               stepper_driving;
    logic signed [31:0] stepper_step_out;

    modport slave (
        input  cmd_valid, cmd_step, cmd_speed, flush, stepper_driving, stepper_step_out,
        output cmd_ready, stepper_step_in, stepper_speed, start_driving
    );

    modport master (
        output cmd_valid, cmd_step, cmd_speed, flush, stepper_driving, stepper_step_out,
        input  cmd_ready, stepper_step_in, stepper_speed, start_driving
    );
endinterface

// File: rtl/z_move_sequencer.sv
// Buffers Z move commands and issues them one at a time to the stepper stage,
// tracking accumulated position and flagging moves that end early or never start.
module z_move_sequencer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    z_move_sequencer_if.slave             bus,
    output logic                          busy,
    output logic                          done,
    output logic                          fault,
    output logic signed [31:0]            position,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, RUN, COMPLETE, ABORT} state_t;

    state_t             state_q, state_d;
    logic [63:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      cnt_q;
    logic signed [31:0] cur_step_q, cur_step_d;
    logic [31:0]        cur_speed_q, cur_speed_d;
    logic signed [31:0] pos_q, pos_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               zero_q, zero_d;
    logic               push, pop;
    logic signed [31:0] head_step;
    logic [31:0]        head_speed;
    logic signed [31:0] executed;

    assign bus.cmd_ready = (cnt_q != CW'(FIFO_DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready && !bus.flush;
    assign head_step     = mem_q[rd_ptr_q][63:32];
    assign head_speed    = mem_q[rd_ptr_q][31:0];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.cmd_step, bus.cmd_speed};
    end

    // Flush drops everything still queued; a command popped this cycle has already left the queue.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_step_q  <= '0;
            cur_speed_q <= 32'd1;
            pos_q       <= '0;
            tmo_q       <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_step_q  <= cur_step_d;
            cur_speed_q <= cur_speed_d;
            pos_q       <= pos_d;
            tmo_q       <= tmo_d;
            zero_q      <= zero_d;
        end
    end

    assign executed = cur_step_q - bus.stepper_step_out;

    always_comb begin
        state_d     = state_q;
        cur_step_d  = cur_step_q;
        cur_speed_d = cur_speed_q;
        pos_d       = pos_q;
        tmo_d       = tmo_q;
        zero_d      = zero_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                // Waiting on stepper_driving also covers a stepper left running across a reset.
                if (cnt_q != '0 && !bus.stepper_driving) begin
                    pop         = 1'b1;
                    cur_step_d  = head_step;
                    cur_speed_d = (head_speed == 32'd0) ? 32'd1 : head_speed;
                    tmo_d       = '0;
                    zero_d      = (head_step[30:0] == 31'd0);
                    state_d     = (head_step[30:0] == 31'd0) ? COMPLETE : ISSUE;
                end
            end
            ISSUE: begin
                if (bus.stepper_driving)   state_d = RUN;
                else if (tmo_q == TMO_LAST) state_d = ABORT;
                else                       tmo_d   = tmo_q + TW'(1);
            end
            RUN: begin
                if (!bus.stepper_driving) state_d = COMPLETE;
            end
            COMPLETE: begin
                if (!zero_q) pos_d = pos_q + executed;
                state_d = IDLE;
            end
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.start_driving   = (state_q == ISSUE);
    assign bus.stepper_step_in = cur_step_q;
    assign bus.stepper_speed   = cur_speed_q;
    assign done                = (state_q == COMPLETE) || (state_q == ABORT);
    assign fault               = (state_q == ABORT) ||
                                 ((state_q == COMPLETE) && !zero_q && (bus.stepper_step_out != 32'sd0));
    assign busy                = (state_q != IDLE) || (cnt_q != '0);
    assign position            = pos_q;
    assign fifo_count          = cnt_q;
endmodule

// File: tb/tb_z_move_sequencer.sv
// Directed bench for z_move_sequencer with a behavioural stepper stage model.
module tb_z_move_sequencer;
    logic               clk = 1'b0;
    logic               reset;
    logic               busy, done, fault;
    logic signed [31:0] position;
    logic [2:0]         fifo_count;

    z_move_sequencer_if bus ();

    z_move_sequencer #(.FIFO_DEPTH(4), .START_TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .position   (position),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Stepper model controls
    int                 run_len  = 5;
    int                 run_left = 0;
    logic signed [31:0] stop_rem = 0;
    logic               dead     = 1'b0;

    // Per-test statistics
    int   st_hi, st_rise, gap_min, gap_cur, done_cnt, fault_cnt, df_cnt;
    logic st_prev;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic clear_stats();
        st_hi = 0; st_rise = 0; gap_min = 1000; gap_cur = 0;
        done_cnt = 0; fault_cnt = 0; df_cnt = 0; st_prev = 1'b0;
    endtask

    // One clock: observe outputs just after the edge, then let the stepper react.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.start_driving) st_hi++;
        else gap_cur++;
        if (bus.start_driving && !st_prev) begin
            st_rise++;
            if (st_rise > 1 && gap_cur < gap_min) gap_min = gap_cur;
            gap_cur = 0;
        end
        st_prev = bus.start_driving;
        if (done) done_cnt++;
        if (fault) fault_cnt++;
        if (done && fault) df_cnt++;
        if (!dead) begin
            if (!bus.stepper_driving) begin
                if (bus.start_driving) begin
                    bus.stepper_driving  = 1'b1;
                    run_left             = run_len;
                    bus.stepper_step_out = bus.stepper_step_in;
                end
            end else if (run_left == 0) begin
                bus.stepper_driving  = 1'b0;
                bus.stepper_step_out = stop_rem;
            end else begin
                run_left--;
            end
        end
    endtask

    task automatic push(input logic signed [31:0] s, input logic [31:0] sp);
        bus.cmd_valid = 1'b1;
        bus.cmd_step  = s;
        bus.cmd_speed = sp;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (busy && n < budget);
        chk(tag, busy, 1'b0);
    endtask

    task automatic apply_reset();
        reset                = 1'b1;
        bus.cmd_valid        = 1'b0;
        bus.flush            = 1'b0;
        bus.stepper_driving  = 1'b0;
        bus.stepper_step_out = 0;
        run_left             = 0;
        step();
        step();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},  bus.cmd_ready, 1);
        chk({tag, "_start"},  bus.start_driving, 0);
        chk({tag, "_done"},   done, 0);
        chk({tag, "_fault"},  fault, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_pos"},    position, 0);
        chk({tag, "_stepin"}, bus.stepper_step_in, 0);
        chk({tag, "_speed"},  bus.stepper_speed, 1);
        chk({tag, "_count"},  fifo_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_step  = 0;
        bus.cmd_speed = 0;
        clear_stats();

        // Reset values
        apply_reset();
        chk_reset_vals("rst");
        reset = 1'b0;

        // Single +100 move, also checks push-to-start latency
        clear_stats();
        run_len = 5; stop_rem = 0;
        push(100, 2);
        chk("lat_count", fifo_count, 1);
        chk("lat_start0", bus.start_driving, 0);
        chk("lat_busy", busy, 1);
        step();
        chk("lat_start1", bus.start_driving, 1);
        chk("lat_stepin", bus.stepper_step_in, 100);
        chk("lat_speed", bus.stepper_speed, 2);
        wait_idle("t1_idle", 200);
        chk("t1_done", done_cnt, 1);
        chk("t1_fault", fault_cnt, 0);
        chk("t1_pos", position, 100);

        // Zero speed promoted to 1
        push(7, 0);
        step();
        chk("spd0_speed", bus.stepper_speed, 1);
        chk("spd0_stepin", bus.stepper_step_in, 7);
        wait_idle("spd0_idle", 200);
        chk("spd0_pos", position, 107);

        // Back-to-back -50 then +20
        apply_reset();
        reset = 1'b0;
        clear_stats();
        push(-50, 3);
        push(20, 3);
        wait_idle("b2b_idle", 300);
        chk("b2b_issues", st_rise, 2);
        chk("b2b_gap", (gap_min >= 1), 1);
        chk("b2b_done", done_cnt, 2);
        chk("b2b_fault", fault_cnt, 0);
        chk("b2b_pos", position, -30);

        // Endstop: stepper stops with 40 steps remaining
        apply_reset();
        reset = 1'b0;
        clear_stats();
        stop_rem = 40;
        push(100, 2);
        wait_idle("end_idle", 200);
        chk("end_done", done_cnt, 1);
        chk("end_donefault", df_cnt, 1);
        chk("end_pos", position, 60);
        stop_rem = 0;

        // Stepper never responds: start timeout then abort
        apply_reset();
        reset = 1'b0;
        clear_stats();
        dead = 1'b1;
        push(100, 2);
        wait_idle("tmo_idle", 100);
        chk("tmo_hi", st_hi, 16);
        chk("tmo_done", done_cnt, 1);
        chk("tmo_donefault", df_cnt, 1);
        chk("tmo_pos", position, 0);
        dead = 1'b0;

        // Buffer full, refused push, flush (winning over a push) during a running move
        apply_reset();
        reset = 1'b0;
        clear_stats();
        run_len = 40;
        push(10, 2);
        push(1, 2);
        push(2, 2);
        push(3, 2);
        push(4, 2);
        chk("full_count", fifo_count, 4);
        chk("full_ready", bus.cmd_ready, 0);
        push(5, 2);
        chk("full_refused", fifo_count, 4);
        bus.flush = 1'b1;
        push(6, 2);
        bus.flush = 1'b0;
        chk("flush_count", fifo_count, 0);
        chk("flush_running", bus.stepper_driving, 1);
        wait_idle("flush_idle", 200);
        chk("flush_done", done_cnt, 1);
        chk("flush_fault", fault_cnt, 0);
        chk("flush_pos", position, 10);

        // Zero-step command with a stale nonzero step_out must not fault or move
        clear_stats();
        bus.stepper_step_out = 5;
        push(0, 5);
        wait_idle("zero_idle", 50);
        chk("zero_done", done_cnt, 1);
        chk("zero_fault", fault_cnt, 0);
        chk("zero_start", st_hi, 0);
        chk("zero_pos", position, 10);

        // Reset during RUN, then no reissue while stepper still driving
        run_len = 20;
        push(100, 2);
        step();
        step();
        step();
        chk("rr_running", bus.stepper_driving, 1);
        reset = 1'b1;
        step();
        chk_reset_vals("rr");
        reset = 1'b0;
        clear_stats();
        push(5, 2);
        step();
        step();
        chk("rr_hold_start", st_hi, 0);
        chk("rr_hold_busy", busy, 1);
        wait_idle("rr_idle", 200);
        chk("rr_done", done_cnt, 1);
        chk("rr_fault", fault_cnt, 0);
        chk("rr_pos", position, 5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/z_move_sequencer.md
Z_MOVE_SEQUENCER -- requirements
Module: z_move_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command buffer depth (power of two, >=2).
REQ-002 Parameter START_TIMEOUT, default 16, cycles to wait for stepper_driving after start_driving asserts.
REQ-003 clk  in  1  sole clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command offered; cmd_ready  out  1  buffer not full; transfer when both high.
REQ-006 cmd_step  in  32  signed two's-complement step count (bit31 = direction); cmd_speed  in  32  half-period in clk cycles.
REQ-007 flush  in  1  discard all buffered (not yet issued) commands.
REQ-008 stepper_step_in  out  32, stepper_speed  out  32, start_driving  out  1: drive the Z stepper stage.
REQ-009 stepper_driving  in  1, stepper_step_out  in  32: stepper busy flag and remaining signed steps.
REQ-010 busy  out  1 (state != IDLE or buffer non-empty); done  out  1 (one-cycle pulse per retired command); fault  out  1 (one-cycle pulse, with done, when move ended early or never started).
REQ-011 position  out  32  signed accumulated executed steps; fifo_count  out  $clog2(FIFO_DEPTH)+1.

Function
REQ-012 Buffer: FIFO of {cmd_step, cmd_speed}; cmd_ready = (fifo_count != FIFO_DEPTH); push ignored when full; push and pop in same cycle leave count unchanged.
REQ-013 flush empties the buffer next cycle, does not affect a command already in ISSUE/RUN; flush wins over a simultaneous push.
REQ-014 States: IDLE, ISSUE, RUN, COMPLETE, ABORT.
REQ-015 IDLE: when buffer non-empty and stepper_driving==0, pop head into cur_step/cur_speed; if cur_step[30:0]==0 go COMPLETE directly (no issue, counts as zero-step success), else go ISSUE.
REQ-016 cur_speed of 0 SHALL be replaced by 1 when popped.
REQ-017 stepper_step_in = cur_step and stepper_speed = cur_speed, held stable from ISSUE entry through end of RUN.
REQ-018 ISSUE: start_driving=1; timeout counter increments each cycle; on stepper_driving==1 go RUN; if counter reaches START_TIMEOUT first go ABORT.
REQ-019 RUN: start_driving=0 (re-arms stepper handshake); stay until stepper_driving==0, then go COMPLETE.
REQ-020 COMPLETE (one cycle): executed = cur_step - stepper_step_out (32-bit wrap); position += executed; done=1; fault=1 iff stepper_step_out != 0; go IDLE. Zero-step path: executed=0, fault=0.
REQ-021 ABORT (one cycle): start_driving=0, done=1, fault=1, position unchanged; go IDLE.
REQ-022 start_driving SHALL never be high outside ISSUE; minimum one low cycle between successive ISSUE phases.
REQ-023 Latency: push into empty buffer with stepper idle -> start_driving high 2 cycles later (push registered, pop, ISSUE).
REQ-024 position wraps modulo 2^32; no saturation.

Reset
REQ-025 On reset: state IDLE, buffer empty, fifo_count=0, cmd_ready=1, start_driving=0, done=0, fault=0, busy=0, position=0, stepper_step_in=0, stepper_speed=1, timeout counter 0.
REQ-026 Reset mid-ISSUE/RUN abandons the command without done; sequencer will not issue again until stepper_driving==0.

Verification
REQ-027 Push step=+100, speed=2; stepper model runs to 0 -> one done, fault=0, position=100.
REQ-028 Push -50 then +20 back-to-back -> two ISSUE phases separated by >=1 low start_driving cycle; final position=-30.
REQ-029 Push +100, stepper stops with step_out=+40 (endstop) -> done+fault same cycle, position=60.
REQ-030 Stepper never asserts driving -> start_driving high exactly 16 cycles, then done+fault, position unchanged.
REQ-031 Push 5 commands at DEPTH=4 with stepper busy -> 5th refused (cmd_ready=0); flush -> fifo_count=0 next cycle, running move still completes.
REQ-032 Push step=0 -> done pulse, fault=0, start_driving never asserted; reset during RUN -> all outputs at reset values next cycle.
